// File: rtl/count_report_pkg.sv
// Shared types and constants for the counter UART reporter.
package count_report_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND,
        DRAIN
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         MSG_LEN    = 5;

endpackage

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with valid/ready input; accepts the next byte during
// the final stop-bit cycle so consecutive frames abut with no idle gap.
module uart_tx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_12m,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [3:0]       STOP_IDX = 4'd9;

    logic [CNT_W-1:0] baud_cnt_reg;
    logic [3:0]       bit_idx_reg;
    logic [8:0]       shift_reg;
    logic             active_reg;
    logic             tx_reg;
    logic             bit_done;

    assign bit_done = (baud_cnt_reg == LAST_CNT);
    assign ready    = !active_reg || (bit_done && (bit_idx_reg == STOP_IDX));
    assign tx       = tx_reg;

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '1;
            active_reg   <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (valid && ready) begin
            // Start bit goes out now; shift holds data LSB first then stop bit.
            shift_reg    <= {1'b1, data};
            tx_reg       <= 1'b0;
            active_reg   <= 1'b1;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
        end else if (active_reg) begin
            if (bit_done) begin
                baud_cnt_reg <= '0;
                if (bit_idx_reg == STOP_IDX) begin
                    active_reg <= 1'b0;
                end else begin
                    tx_reg      <= shift_reg[0];
                    shift_reg   <= {1'b1, shift_reg[8:1]};
                    bit_idx_reg <= bit_idx_reg + 4'd1;
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_uart_reporter.sv
// Reports every new value of an 8-bit counter as "DDD\r\n" over UART 8N1,
// coalescing changes that arrive while a message is in flight.
module count_uart_reporter
    import count_report_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_12m,
    input  logic       rst,
    input  logic [7:0] count,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sent_value
);
    localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

    state_t     state_reg;
    logic [7:0] work_reg;
    logic [3:0] digit_reg [3];
    logic [2:0] idx_reg;
    logic       busy_reg;
    logic [7:0] sent_value_reg;
    logic [7:0] msg_chars [MSG_LEN];
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // digit_reg[0] is hundreds, [1] tens, [2] units
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit_ascii
            assign msg_chars[gi] = ASCII_ZERO + {4'd0, digit_reg[gi]};
        end
    endgenerate
    assign msg_chars[3] = ASCII_CR;
    assign msg_chars[4] = ASCII_LF;

    always_comb begin
        tx_data = ASCII_LF;
        case (idx_reg)
            3'd0:    tx_data = msg_chars[0];
            3'd1:    tx_data = msg_chars[1];
            3'd2:    tx_data = msg_chars[2];
            3'd3:    tx_data = msg_chars[3];
            default: tx_data = msg_chars[4];
        endcase
    end

    assign tx_valid   = (state_reg == SEND);
    assign busy       = busy_reg;
    assign sent_value = sent_value_reg;

    always_ff @(posedge clk_12m) begin
        if (rst) begin
            state_reg      <= IDLE;
            work_reg       <= '0;
            digit_reg[0]   <= '0;
            digit_reg[1]   <= '0;
            digit_reg[2]   <= '0;
            idx_reg        <= '0;
            busy_reg       <= 1'b0;
            sent_value_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count != sent_value_reg) begin
                        sent_value_reg <= count;
                        work_reg       <= count;
                        digit_reg[0]   <= '0;
                        digit_reg[1]   <= '0;
                        digit_reg[2]   <= '0;
                        busy_reg       <= 1'b1;
                        state_reg      <= CONV;
                    end
                end
                CONV: begin
                    // Repeated subtraction: one hundreds or tens step per clock.
                    if (work_reg >= 8'd100) begin
                        work_reg     <= work_reg - 8'd100;
                        digit_reg[0] <= digit_reg[0] + 4'd1;
                    end else if (work_reg >= 8'd10) begin
                        work_reg     <= work_reg - 8'd10;
                        digit_reg[1] <= digit_reg[1] + 4'd1;
                    end else begin
                        digit_reg[2] <= work_reg[3:0];
                        idx_reg      <= '0;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DRAIN;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    // ready here means the LF stop bit is in its last cycle.
                    if (tx_ready) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_uart_tx (
        .clk_12m(clk_12m),
        .rst    (rst),
        .data   (tx_data),
        .valid  (tx_valid),
        .ready  (tx_ready),
        .tx     (tx)
    );

endmodule

// File: tb/tb_count_uart_reporter.sv
// Scoreboard bench: stimulus pushes expected characters, a UART decoder pops and checks.
module tb_count_uart_reporter;

    localparam int BIT_CLKS   = 104;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
    localparam int MSG_CLKS   = 5215;

    logic       clk_12m = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic       tx;
    logic       busy;
    logic [7:0] sent_value;

    count_uart_reporter dut (
        .clk_12m   (clk_12m),
        .rst       (rst),
        .count     (count),
        .tx        (tx),
        .busy      (busy),
        .sent_value(sent_value)
    );

    always #5 clk_12m = ~clk_12m;

    int cyc = 0;
    always @(posedge clk_12m) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ch;
        int         pos;
        bit         chk_lat;
        int         t_issue;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: what the reporter should have sent / will send.
    int model_sent    = 0;
    int model_pending = 0;
    bit model_busy    = 0;
    int model_end     = 0;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void push_msg(int v, bit chk, int t);
        int chars[5];
        chars[0] = 8'h30 + v / 100;
        chars[1] = 8'h30 + (v / 10) % 10;
        chars[2] = 8'h30 + v % 10;
        chars[3] = 8'h0D;
        chars[4] = 8'h0A;
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.ch      = chars[i][7:0];
            e.pos     = i;
            e.chk_lat = chk && (i == 0);
            e.t_issue = t;
            exp_q.push_back(e);
        end
        $display("issue value=%0d at cycle %0d", v, t);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_12m);
        #1;
    endtask

    // Called just after a rising edge; snapshot happens on the next edge.
    task automatic set_count(input int v);
        count = v[7:0];
        if (model_busy) begin
            model_pending = v;
        end else if (v != model_sent) begin
            push_msg(v, 1'b1, cyc);
            model_sent    = v;
            model_pending = v;
            model_busy    = 1'b1;
            model_end     = cyc + MSG_CLKS;
            wait_cyc(1);
            check("busy_rise", busy, 1);
        end
    endtask

    task automatic settle();
        while (model_busy) begin
            while (cyc < model_end + 50) wait_cyc(1);
            if (model_pending != model_sent) begin
                push_msg(model_pending, 1'b0, cyc);
                model_sent = model_pending;
                model_end  = model_end + MSG_CLKS;
            end else begin
                model_busy = 1'b0;
            end
        end
        check("busy_idle", busy, 0);
        check("sent_value", sent_value, model_sent);
    endtask

    // ---------------- UART monitor ----------------
    logic prev_tx  = 1'b1;
    int   last_start = 0;

    task automatic wait_neg(input int n, inout bit ab);
        for (int k = 0; k < n && !ab; k++) begin
            @(negedge clk_12m);
            if (rst) ab = 1'b1;
        end
    endtask

    task automatic decode_frame();
        int         start_cyc;
        logic [9:0] fr;
        bit         ab;
        exp_t       e;
        start_cyc = cyc;
        ab        = 1'b0;
        fr        = '0;
        for (int i = 0; i < 10; i++) begin
            wait_neg((i == 0) ? BIT_CLKS / 2 : BIT_CLKS, ab);
            if (ab) break;
            fr[i] = tx;
        end
        prev_tx = 1'b1;
        if (ab) return;
        check("frame_bits", {31'd0, fr[0]} + {31'd0, !fr[9]}, 0);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", fr[8:1], 256);
        end else begin
            e = exp_q.pop_front();
            $display("rx char=0x%02h expect=0x%02h pos=%0d start=%0d", fr[8:1], e.ch, e.pos, start_cyc);
            check("rx_char", fr[8:1], e.ch);
            if (e.pos != 0) check("start_spacing", start_cyc - last_start, FRAME_CLKS);
            if (e.chk_lat) begin
                total++;
                if (start_cyc - e.t_issue > 14 || start_cyc - e.t_issue < 1) begin
                    bad++;
                    $display("FAIL first_start_latency actual=%0d required=1..14", start_cyc - e.t_issue);
                end
            end
        end
        last_start = start_cyc;
    endtask

    initial begin
        forever begin
            @(negedge clk_12m);
            if (rst) prev_tx = 1'b1;
            else if (prev_tx && !tx) decode_frame();
            else prev_tx = tx;
        end
    end

    // ---------------- Stimulus ----------------
    initial begin
        int viol;
        int n;
        int v;
        rst   = 1'b1;
        count = 8'd0;
        wait_cyc(3);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_sent_value", sent_value, 0);
        rst = 1'b0;

        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            wait_cyc(1);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("idle_quiet_violations", viol, 0);
        check("idle_sent_value", sent_value, 0);

        set_count(42);
        n = 0;
        while (busy && n < 6000) begin
            wait_cyc(1);
            n++;
        end
        total++;
        if (n < 5186 || n > 5214) begin
            bad++;
            $display("FAIL busy_duration actual=%0d required=5200+-14", n);
        end
        settle();

        set_count(255); settle();
        set_count(0);   settle();
        set_count(9);   settle();
        set_count(10);  settle();

        set_count(1);
        wait_cyc(500);  set_count(2);
        wait_cyc(1000); set_count(3);
        wait_cyc(1000); set_count(7);
        settle();
        check("coalesce_final", sent_value, 7);

        for (int t = 0; t < 2; t++) begin
            do v = $urandom_range(0, 255); while (v == model_sent);
            set_count(v);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                wait_cyc($urandom_range(200, 1400));
                set_count($urandom_range(0, 255));
            end
            settle();
        end

        set_count(123);
        wait_cyc(2500);
        rst = 1'b1;
        wait_cyc(1);
        check("midreset_tx", tx, 1);
        check("midreset_busy", busy, 0);
        check("midreset_sent_value", sent_value, 0);
        exp_q.delete();
        model_sent    = 0;
        model_pending = 0;
        model_busy    = 1'b0;
        count         = 8'd5;
        wait_cyc(3);
        rst = 1'b0;
        set_count(5);
        settle();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
